// File: rtl/adc_arb_pkg.sv
// Shared ADC arbiter definitions: sample width from the ADC config and FSM state encodings.
package adc_arb_pkg;
  localparam int ADC_WIDTH = 12;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ADC = 2'd1,
    ST_DELIVER  = 2'd2
  } arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: scans the request vector starting at the pointer, returns one-hot grant and index.
module rr_arbiter
  import adc_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);

  localparam logic [IW:0] NW = (IW+1)'(NUM_REQ);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_cand;
  logic          w_found;

  assign o_any = |i_req;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Pointer is always below NUM_REQ, so one subtraction performs the wrap.
      w_sum = {1'b0, i_ptr} + (IW+1)'(i);
      if (w_sum >= NW) w_sum = w_sum - NW;
      w_cand = w_sum[IW-1:0];
      if (!w_found && i_req[w_cand]) begin
        w_found       = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/adc_arbiter.sv
// Shares one ADC between NUM_REQ requesters, delivering only fresh samples (rising adc_d_valid).
// Optional response timeout enabled by defining ADC_ARB_TIMEOUT_EN.
module adc_arbiter
  import adc_arb_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int IW             = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [ADC_WIDTH-1:0] rsp_data,
  input  logic                 adc_d_valid,
  output logic                 adc_d_ready,
  input  logic [ADC_WIDTH-1:0] adc_value,
  output logic [IW-1:0]        grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("adc_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 1");
  end

  arb_state_t           r_state;
  logic [IW-1:0]        r_ptr;
  logic [IW-1:0]        r_grant_id;
  logic [NUM_REQ-1:0]   r_req_ready;
  logic                 r_adc_q;
  logic [ADC_WIDTH-1:0] r_data;
  logic [NUM_REQ-1:0]   w_gnt;
  logic [IW-1:0]        w_idx;
  logic                 w_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

`ifdef ADC_ARB_TIMEOUT_EN
  localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] r_cnt;
  logic          r_timeout_err;
  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_grant_id  <= '0;
      r_req_ready <= '0;
      // Any sample already pending at reset release counts as stale.
      r_adc_q     <= 1'b1;
`ifdef ADC_ARB_TIMEOUT_EN
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
      r_adc_q     <= adc_d_valid;
      r_req_ready <= '0;
`ifdef ADC_ARB_TIMEOUT_EN
      r_timeout_err <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant_id  <= w_idx;
            r_req_ready <= w_gnt;
            r_ptr       <= (w_idx == LAST_IDX) ? '0 : w_idx + IW'(1);
            r_state     <= ST_WAIT_ADC;
          end
        end
        ST_WAIT_ADC: begin
          if (adc_d_valid && !r_adc_q) begin
            r_data  <= adc_value;
            r_state <= ST_DELIVER;
`ifdef ADC_ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        ST_DELIVER: begin
          if (rsp_ready[r_grant_id]) begin
            r_state <= ST_IDLE;
          end
`ifdef ADC_ARB_TIMEOUT_EN
          else if (r_cnt == LAST_CNT) begin
            r_state       <= ST_IDLE;
            r_timeout_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign grant_id    = r_grant_id;
  assign busy        = (r_state != ST_IDLE);
  assign adc_d_ready = (r_state == ST_WAIT_ADC);
  assign rsp_valid   = (r_state == ST_DELIVER) ? (NUM_REQ'(1) << r_grant_id) : '0;
  assign rsp_data    = (r_state == ST_DELIVER) ? r_data : '0;

endmodule

// File: doc/adc_arbiter.md
ADC_ARBITER -- requirements
Module: adc_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the ADC, range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: response-accept timeout, used only with ADC_ARB_TIMEOUT_EN.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  NUM_REQ  per-requester sample request; held until req_ready.
REQ-007 req_ready  out  NUM_REQ  one-cycle grant/accept pulse per requester.
REQ-008 rsp_valid  out  NUM_REQ  sample available for the granted requester.
REQ-009 rsp_ready  in  NUM_REQ  requester accepts the sample.
REQ-010 rsp_data  out  ADC_WIDTH  shared sample bus; valid only while any rsp_valid is high.
REQ-011 adc_d_valid  in  1  ADC sample-ready flag.
REQ-012 adc_d_ready  out  1  ADC acknowledge; stalls the ADC while low.
REQ-013 adc_value  in  ADC_WIDTH  ADC sample.
REQ-014 grant_id  out  clog2(NUM_REQ)  index of the current or last grant.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 timeout_err  out  1  one-cycle pulse on response timeout; constant 0 without ADC_ARB_TIMEOUT_EN.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT_ADC and DELIVER.
REQ-018 IDLE: if any req_valid is high, the arbiter SHALL pick a requester round-robin, starting at (last grant + 1) mod NUM_REQ, register grant_id, pulse req_ready[grant_id] the following cycle, and enter WAIT_ADC that same cycle.
REQ-019 IDLE with no req_valid high: the FSM SHALL hold; adc_d_ready=0, so the ADC stalls with at most one stale sample pending.
REQ-020 WAIT_ADC: adc_d_ready=1; the FSM SHALL capture adc_value only on a rising edge of adc_d_valid (registered adc_d_valid_q=0 and adc_d_valid=1), then enter DELIVER.
REQ-021 An adc_d_valid already high on entry to WAIT_ADC is stale: it SHALL be acknowledged and discarded, never delivered.
REQ-022 DELIVER: adc_d_ready=0; rsp_valid[grant_id]=1 and rsp_data=captured sample, both stable until rsp_ready[grant_id]; on the handshake return to IDLE next cycle.
REQ-023 At most one rsp_valid bit and one req_ready bit SHALL be high in any cycle.
REQ-024 req_valid SHALL be sampled only in IDLE; rsp_ready of non-granted requesters SHALL be ignored.
REQ-025 Minimum latency from req_ready pulse to rsp_valid: one cycle after the fresh adc_d_valid rising edge.
REQ-026 Round-robin pointer wraps from NUM_REQ-1 to 0; an all-requesters-active load SHALL grant 0,1,..,NUM_REQ-1,0 in turn.

Reset
REQ-027 When rst is high, the FSM SHALL enter IDLE, round-robin pointer SHALL restart so requester 0 wins first, adc_d_valid_q SHALL be set to 1, and all outputs SHALL be 0, including grant_id.
REQ-028 rst asserted in WAIT_ADC or DELIVER SHALL abort the transaction; the captured sample SHALL be dropped and no rsp_valid SHALL follow.

Configuration
REQ-029 With ADC_ARB_TIMEOUT_EN defined, a counter SHALL run in DELIVER; after TIMEOUT_CYCLES cycles without rsp_ready, rsp_valid SHALL drop, timeout_err SHALL pulse one cycle, and the FSM SHALL return to IDLE.
REQ-030 Without ADC_ARB_TIMEOUT_EN, DELIVER SHALL wait indefinitely and timeout_err SHALL be tied 0.

Structure
REQ-031 State encodings and the ADC_WIDTH constant SHALL live in a shared package (adc_arb_pkg); ADC_WIDTH comes from the existing ADC config.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (request vector + pointer -> one-hot grant + index).

Verification
REQ-033 Reset release with adc_d_valid=1 -> no capture until adc_d_valid falls and rises again; busy=0 while idle.
REQ-034 req_valid=4'b1111 held for 8 transactions, rsp_ready=1 -> grant_id sequence 0,1,2,3,0,1,2,3.
REQ-035 Single request on requester 2; adc_value=12'hABC on a fresh edge -> req_ready[2] one-cycle pulse, rsp_valid[2]=1, rsp_data=12'hABC.
REQ-036 Stale sample 12'h111 pending at grant, fresh sample 12'h222 -> requester receives 12'h222 only.
REQ-037 rst pulsed during WAIT_ADC -> all outputs 0 next cycle, no rsp_valid, next grant goes to requester 0.
REQ-038 ADC_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=255, rsp_ready held 0 -> rsp_valid drops and timeout_err pulses one cycle after 255 DELIVER cycles; without the macro, rsp_valid stays high.
